// File: rtl/register_unit_gen2_pkg.sv
// Shared constants for the datapath register unit: register map indices,
// memory-port FSM state encoding and the B-mux index validity check.
package regunit_pkg;

    localparam int IDX_PC  = 0;
    localparam int IDX_IR  = 1;
    localparam int IDX_MDR = 2;
    localparam int IDX_MAR = 3;
    localparam int IDX_AC  = 4;
    localparam int IDX_R0  = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic idx_valid(input int idx, input int ngpr);
        return (idx >= 0) && (idx < IDX_R0 + ngpr);
    endfunction

endpackage

// File: rtl/register_unit_gen2_mem_port_fsm.sv
// Data-memory handshake sequencer with wait-state timeout and sticky error flag.
//  state   | meaning
//  IDLE    | no access; MEM_RD/MEM_WR start one
//  WAIT    | DMEM_REQ high, waiting for DMEM_ACK or timeout
//  DONE    | one-cycle completion pulse, request dropped
module mem_port_fsm
    import regunit_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_rd,
    input  logic mem_wr,
    input  logic dmem_ack,
    input  logic err_clr,
    output logic busy,
    output logic mem_done,
    output logic mem_err,
    output logic dmem_req,
    output logic dmem_we,
    output logic mdr_ld,
    output logic start
);

    localparam int CW = $clog2(TIMEOUT + 2);
    // Down-counter loaded so that terminal count 0 lands on the TIMEOUT-th wait edge.
    localparam logic [CW-1:0] WLOAD = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [1:0]    state_q;
    logic          is_wr_q;
    logic [CW-1:0] wcnt_q;
    logic          err_q;
    logic          timeout;

    assign start    = (state_q == ST_IDLE) && (mem_rd || mem_wr);
    assign timeout  = (state_q == ST_WAIT) && !dmem_ack && (TIMEOUT != 0) && (wcnt_q == '0);
    assign mdr_ld   = (state_q == ST_WAIT) && dmem_ack && !is_wr_q;
    assign busy     = (state_q != ST_IDLE);
    assign mem_done = (state_q == ST_DONE);
    assign dmem_req = (state_q == ST_WAIT);
    assign dmem_we  = dmem_req && is_wr_q;
    assign mem_err  = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            is_wr_q <= 1'b0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_WAIT;
                        is_wr_q <= !mem_rd;
                        wcnt_q  <= WLOAD;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack || timeout) begin
                        state_q <= ST_DONE;
                    end else if (wcnt_q != '0) begin
                        wcnt_q <= wcnt_q - CW'(1);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase

            if (timeout) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/register_unit_gen2.sv
// Datapath register file (PC, IR, MDR, MAR, AC, R0..Rn) with B-bus source mux
// and a data-memory port whose address is frozen for the duration of an access.
module register_unit_gen2
    import regunit_pkg::*;
#(
    parameter int              DW       = 8,
    parameter int              AW       = 8,
    parameter int              NGPR     = 4,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter int              TIMEOUT  = 15,
    parameter int              SW       = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] C_BUS,
    input  logic          C_WE,
    input  logic [SW-1:0] C_DST,
    input  logic [SW-1:0] B_SEL,
    output logic [DW-1:0] A_BUS,
    output logic [DW-1:0] B_BUS,
    input  logic          IR_LD,
    input  logic          PC_INC,
    input  logic [DW-1:0] INS_BUS,
    output logic [AW-1:0] INS_ADDRESS_BUS,
    output logic [DW-1:0] IR_OUT,
    input  logic          MEM_RD,
    input  logic          MEM_WR,
    output logic          BUSY,
    output logic          MEM_DONE,
    output logic          MEM_ERR,
    input  logic          ERR_CLR,
    output logic          DMEM_REQ,
    output logic          DMEM_WE,
    output logic [AW-1:0] DMEM_ADDR,
    output logic [DW-1:0] DMEM_WDATA,
    input  logic [DW-1:0] DMEM_RDATA,
    input  logic          DMEM_ACK
);

    logic [AW-1:0] pc, mar, addr_q;
    logic [DW-1:0] ir, mdr, ac;
    logic [DW-1:0] gpr [NGPR];
    logic          mdr_ld, start, busy;

    mem_port_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_rd   (MEM_RD),
        .mem_wr   (MEM_WR),
        .dmem_ack (DMEM_ACK),
        .err_clr  (ERR_CLR),
        .busy     (busy),
        .mem_done (MEM_DONE),
        .mem_err  (MEM_ERR),
        .dmem_req (DMEM_REQ),
        .dmem_we  (DMEM_WE),
        .mdr_ld   (mdr_ld),
        .start    (start)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            ir     <= '0;
            mdr    <= '0;
            mar    <= '0;
            ac     <= '0;
            addr_q <= '0;
            for (int i = 0; i < NGPR; i++) gpr[i] <= '0;
        end else begin
            if (C_WE && C_DST == SW'(IDX_PC)) begin
                pc <= AW'(C_BUS);
            end else if (PC_INC) begin
                pc <= pc + AW'(1);
            end
            if (IR_LD) ir <= INS_BUS;
            // Read data owns MDR during an access; ALU writes only land when idle.
            if (mdr_ld) begin
                mdr <= DMEM_RDATA;
            end else if (C_WE && C_DST == SW'(IDX_MDR) && !busy) begin
                mdr <= C_BUS;
            end
            if (C_WE && C_DST == SW'(IDX_MAR)) mar <= AW'(C_BUS);
            if (C_WE && C_DST == SW'(IDX_AC))  ac  <= C_BUS;
            for (int i = 0; i < NGPR; i++) begin
                if (C_WE && C_DST == SW'(IDX_R0 + i)) gpr[i] <= C_BUS;
            end
            if (start) addr_q <= mar;
        end
    end

    always_comb begin
        B_BUS = '0;
        if (idx_valid(int'(B_SEL), NGPR)) begin
            if (B_SEL == SW'(IDX_PC))  B_BUS = DW'(pc);
            if (B_SEL == SW'(IDX_IR))  B_BUS = ir;
            if (B_SEL == SW'(IDX_MDR)) B_BUS = mdr;
            if (B_SEL == SW'(IDX_MAR)) B_BUS = DW'(mar);
            if (B_SEL == SW'(IDX_AC))  B_BUS = ac;
            for (int i = 0; i < NGPR; i++) begin
                if (B_SEL == SW'(IDX_R0 + i)) B_BUS = gpr[i];
            end
        end
    end

    assign BUSY            = busy;
    assign A_BUS           = ac;
    assign IR_OUT          = ir;
    assign INS_ADDRESS_BUS = pc;
    assign DMEM_ADDR       = busy ? addr_q : mar;
    assign DMEM_WDATA      = mdr;

endmodule

// File: tb/tb_register_unit_gen2.sv
// Scoreboard bench for register_unit_gen2: stimulus queues expected values,
// monitors compare at the falling edge and on every MEM_DONE pulse.
module tb_register_unit_gen2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] C_BUS, INS_BUS, DMEM_RDATA;
    logic       C_WE, IR_LD, PC_INC, MEM_RD, MEM_WR, ERR_CLR, DMEM_ACK;
    logic [4:0] C_DST, B_SEL;
    logic [7:0] A_BUS, B_BUS, IR_OUT, DMEM_WDATA;
    logic [7:0] INS_ADDRESS_BUS, DMEM_ADDR;
    logic       BUSY, MEM_DONE, MEM_ERR, DMEM_REQ, DMEM_WE;

    register_unit_gen2 #(
        .DW(8), .AW(8), .NGPR(4), .RESET_PC(8'h10), .TIMEOUT(15), .SW(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .C_BUS(C_BUS), .C_WE(C_WE), .C_DST(C_DST),
        .B_SEL(B_SEL), .A_BUS(A_BUS), .B_BUS(B_BUS), .IR_LD(IR_LD),
        .PC_INC(PC_INC), .INS_BUS(INS_BUS), .INS_ADDRESS_BUS(INS_ADDRESS_BUS),
        .IR_OUT(IR_OUT), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .BUSY(BUSY),
        .MEM_DONE(MEM_DONE), .MEM_ERR(MEM_ERR), .ERR_CLR(ERR_CLR),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK)
    );

    always #5 clk = ~clk;

    typedef enum int {K_PC, K_B, K_A, K_IR, K_BUSY, K_REQ, K_WE, K_ADDR, K_ERR, K_DONE} kind_e;
    typedef struct { kind_e kind; logic [7:0] exp; int due; } chk_t;
    typedef struct { logic [7:0] mdr; logic err; } done_t;

    chk_t  chk_q[$];
    done_t done_q[$];
    chk_t  cur;
    done_t dcur;
    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] observe(kind_e k);
        case (k)
            K_PC:   return INS_ADDRESS_BUS;
            K_B:    return B_BUS;
            K_A:    return A_BUS;
            K_IR:   return IR_OUT;
            K_BUSY: return {7'd0, BUSY};
            K_REQ:  return {7'd0, DMEM_REQ};
            K_WE:   return {7'd0, DMEM_WE};
            K_ADDR: return DMEM_ADDR;
            K_ERR:  return {7'd0, MEM_ERR};
            K_DONE: return {7'd0, MEM_DONE};
            default: return 8'hxx;
        endcase
    endfunction

    always @(negedge clk) begin
        while (chk_q.size() > 0 && chk_q[0].due <= cyc) begin
            cur = chk_q.pop_front();
            checks++;
            if (observe(cur.kind) !== cur.exp) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %0h expected %0h",
                         cur.kind.name(), cyc, observe(cur.kind), cur.exp);
            end
        end
        if (MEM_DONE === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_mem_done @cyc %0d", cyc);
            end else begin
                dcur = done_q.pop_front();
                if (DMEM_WDATA !== dcur.mdr || MEM_ERR !== dcur.err) begin
                    errors++;
                    $display("FAIL done_result: got mdr=%0h err=%0b expected mdr=%0h err=%0b",
                             DMEM_WDATA, MEM_ERR, dcur.mdr, dcur.err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(kind_e k, logic [7:0] v);
        chk_q.push_back('{kind: k, exp: v, due: cyc});
    endtask

    task automatic wr(logic [4:0] dst, logic [7:0] val);
        C_WE = 1'b1; C_DST = dst; C_BUS = val;
        tick();
        C_WE = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; C_BUS = '0; C_WE = 1'b0; C_DST = '0; B_SEL = '0;
        IR_LD = 1'b0; PC_INC = 1'b0; INS_BUS = '0; MEM_RD = 1'b0; MEM_WR = 1'b0;
        ERR_CLR = 1'b0; DMEM_RDATA = '0; DMEM_ACK = 1'b0;
        tick(); tick();

        // reset state
        expect_v(K_PC, 8'h10); expect_v(K_BUSY, 0); expect_v(K_REQ, 0);
        expect_v(K_ERR, 0); expect_v(K_DONE, 0); expect_v(K_A, 0);
        rst_n = 1'b1;
        for (int s = 0; s <= 9; s++) begin
            B_SEL = (s == 9) ? 5'd31 : 5'(s);
            expect_v(K_B, (s == 0) ? 8'h10 : 8'h00);
            tick();
        end

        // register writes and B mux
        wr(5'd5, 8'hA5);
        B_SEL = 5'd5; expect_v(K_B, 8'hA5);
        wr(5'd1, 8'h99);
        B_SEL = 5'd1; expect_v(K_B, 8'h00); expect_v(K_IR, 8'h00);
        wr(5'd4, 8'h5A);
        expect_v(K_A, 8'h5A);
        wr(5'd8, 8'hC3);
        B_SEL = 5'd8; expect_v(K_B, 8'hC3);
        wr(5'd9, 8'h66);
        B_SEL = 5'd9; expect_v(K_B, 8'h00);
        tick();
        B_SEL = 5'd31; expect_v(K_B, 8'h00);
        tick();

        // PC wrap, write priority, fetch
        wr(5'd0, 8'hFF);
        expect_v(K_PC, 8'hFF);
        PC_INC = 1'b1; tick();
        expect_v(K_PC, 8'h00);
        wr(5'd0, 8'h42);
        PC_INC = 1'b0;
        expect_v(K_PC, 8'h42);
        IR_LD = 1'b1; PC_INC = 1'b1; INS_BUS = 8'h3C; tick();
        IR_LD = 1'b0; PC_INC = 1'b0;
        expect_v(K_IR, 8'h3C); expect_v(K_PC, 8'h43);

        // read with two wait cycles
        wr(5'd3, 8'h20);
        expect_v(K_ADDR, 8'h20);
        MEM_RD = 1'b1; tick(); MEM_RD = 1'b0;
        expect_v(K_BUSY, 1); expect_v(K_REQ, 1); expect_v(K_WE, 0); expect_v(K_ADDR, 8'h20);
        wr(5'd3, 8'h99);
        expect_v(K_ADDR, 8'h20); expect_v(K_REQ, 1);
        DMEM_ACK = 1'b1; DMEM_RDATA = 8'h77;
        done_q.push_back('{mdr: 8'h77, err: 1'b0});
        tick();
        DMEM_ACK = 1'b0; DMEM_RDATA = 8'h00;
        expect_v(K_DONE, 1); expect_v(K_BUSY, 1); expect_v(K_REQ, 0);
        MEM_RD = 1'b1; tick(); MEM_RD = 1'b0;
        expect_v(K_BUSY, 0); expect_v(K_DONE, 0); expect_v(K_ADDR, 8'h99);
        tick();
        B_SEL = 5'd2; expect_v(K_B, 8'h77); expect_v(K_BUSY, 0);
        tick();

        // write that times out
        wr(5'd2, 8'h55);
        MEM_WR = 1'b1; tick(); MEM_WR = 1'b0;
        done_q.push_back('{mdr: 8'h55, err: 1'b1});
        for (int i = 0; i < 15; i++) begin
            expect_v(K_WE, 1); expect_v(K_REQ, 1); expect_v(K_ERR, 0);
            if (i == 0) begin
                C_WE = 1'b1; C_DST = 5'd2; C_BUS = 8'hAA;
            end else begin
                C_WE = 1'b0;
            end
            tick();
        end
        C_WE = 1'b0;
        expect_v(K_ERR, 1); expect_v(K_DONE, 1); expect_v(K_REQ, 0); expect_v(K_WE, 0);
        tick();
        expect_v(K_ERR, 1); expect_v(K_BUSY, 0);
        ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
        expect_v(K_ERR, 0);
        tick();

        // reset during an access
        MEM_RD = 1'b1; tick(); MEM_RD = 1'b0;
        expect_v(K_BUSY, 1); expect_v(K_REQ, 1);
        MEM_WR = 1'b1; tick(); MEM_WR = 1'b0;
        expect_v(K_BUSY, 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        B_SEL = 5'd2;
        expect_v(K_REQ, 0); expect_v(K_BUSY, 0); expect_v(K_B, 8'h00); expect_v(K_PC, 8'h10);
        tick();
        expect_v(K_BUSY, 0); expect_v(K_REQ, 0);
        tick(); tick();

        checks++;
        if (done_q.size() != 0 || chk_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: got done=%0d chk=%0d expected 0",
                     done_q.size(), chk_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
